// File: rtl/sensor_period_meter_if.sv
// sensor_period_meter_if
//   Groups the mark-sensor input, the measurement enable and the measurement
//   results of sensor_period_meter.
//   slave  : the meter side (takes sensor_in/enable, drives the results)
//   master : the consumer side (drives sensor_in/enable, reads the results)
//   Signals:
//     sensor_in     raw active-low mark sensor, asynchronous
//     enable        measurement enable
//     sensor_level  deglitched sensor level
//     edge_pulse    one-cycle pulse per accepted mark
//     period_raw    last measured period in clk cycles
//     period_avg    moving average of the last 2^AVG_LOG2 periods
//     period_valid  strobe when the outputs update with a full history
//     timeout       marks lost
interface sensor_period_meter_if #(
  parameter int CNT_W = 32
) ();
  logic             sensor_in;
  logic             enable;
  logic             sensor_level;
  logic             edge_pulse;
  logic [CNT_W-1:0] period_raw;
  logic [CNT_W-1:0] period_avg;
  logic             period_valid;
  logic             timeout;

  modport slave (
    input  sensor_in, enable,
    output sensor_level, edge_pulse, period_raw, period_avg, period_valid, timeout
  );

  modport master (
    output sensor_in, enable,
    input  sensor_level, edge_pulse, period_raw, period_avg, period_valid, timeout
  );
endinterface

// File: rtl/sensor_period_meter.sv
// sensor_period_meter
//   Synchronizes and deglitches the active-low print-mark sensor, measures the
//   clk-cycle distance between consecutive marks, keeps a moving average over
//   2^AVG_LOG2 periods and flags loss of marks.
//   Ports:
//     clk    system clock, all logic on posedge
//     rst_n  asynchronous active-low reset
//     bus    sensor_period_meter_if.slave (sensor_in, enable in; results out)
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | no reference mark yet; period counter held at 0
//   ARMED | reference mark seen; each mark yields a period sample
module sensor_period_meter #(
  parameter int SYNC_STAGES = 2,
  parameter int GLITCH_CYC  = 16,
  parameter int CNT_W       = 32,
  parameter int TIMEOUT     = 500000,
  parameter int AVG_LOG2    = 3
) (
  input logic                  clk,
  input logic                  rst_n,
  sensor_period_meter_if.slave bus
);

  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int SUM_W = CNT_W + AVG_LOG2;
  localparam int GW    = $clog2(GLITCH_CYC + 1);

  typedef enum logic {IDLE, ARMED} state_t;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [GW-1:0]          glitch_q, glitch_d;
  logic                   level_q, level_d;
  logic                   edge_q, edge_d;
  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]       hist_q [DEPTH];
  logic [CNT_W-1:0]       hist_d [DEPTH];
  logic [SUM_W-1:0]       sum_q, sum_d;
  logic [AVG_LOG2:0]      fill_q, fill_d;
  logic [CNT_W-1:0]       raw_q, raw_d;
  logic [CNT_W-1:0]       avg_q, avg_d;
  logic                   valid_q, valid_d;
  logic                   timeout_q, timeout_d;

  logic                   synced;
  logic [SUM_W-1:0]       sum_next;
  logic [AVG_LOG2:0]      fill_next;

  assign synced = sync_q[SYNC_STAGES-1];

  // Sync chain and deglitch filter
  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], bus.sensor_in};
    level_d  = level_q;
    glitch_d = '0;
    edge_d   = 1'b0;
    if (synced != level_q) begin
      // Count of differing cycles seen so far; the GLITCH_CYC-th one commits.
      if (glitch_q == GW'(GLITCH_CYC - 1)) begin
        level_d = synced;
        edge_d  = ~synced;
      end else begin
        glitch_d = glitch_q + GW'(1);
      end
    end
  end

  // Oldest sample drops out of the running sum as the new one enters.
  assign sum_next  = sum_q + SUM_W'(cnt_q) - SUM_W'(hist_q[DEPTH-1]);
  assign fill_next = (fill_q == (AVG_LOG2+1)'(DEPTH)) ? fill_q : fill_q + 1'b1;

  // Measurement FSM; edge_q is the accepted mark
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hist_d    = hist_q;
    sum_d     = sum_q;
    fill_d    = fill_q;
    raw_d     = raw_q;
    avg_d     = avg_q;
    valid_d   = 1'b0;
    timeout_d = timeout_q;
    if (!bus.enable) begin
      state_d   = IDLE;
      cnt_d     = '0;
      sum_d     = '0;
      fill_d    = '0;
      timeout_d = 1'b0;
      for (int i = 0; i < DEPTH; i++) hist_d[i] = '0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d = '0;
          if (edge_q) begin
            state_d   = ARMED;
            timeout_d = 1'b0;
            cnt_d     = CNT_W'(1);
          end
        end
        ARMED: begin
          // A mark coinciding with cnt==TIMEOUT is still a valid period.
          if (edge_q) begin
            raw_d     = cnt_q;
            hist_d[0] = cnt_q;
            for (int i = 1; i < DEPTH; i++) hist_d[i] = hist_q[i-1];
            sum_d     = sum_next;
            fill_d    = fill_next;
            cnt_d     = CNT_W'(1);
            if (fill_next == (AVG_LOG2+1)'(DEPTH)) begin
              valid_d = 1'b1;
              avg_d   = sum_next[SUM_W-1:AVG_LOG2];
            end
          end else if (cnt_q == CNT_W'(TIMEOUT)) begin
            state_d   = IDLE;
            timeout_d = 1'b1;
            cnt_d     = '0;
            sum_d     = '0;
            fill_d    = '0;
            for (int i = 0; i < DEPTH; i++) hist_d[i] = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= '1;
      glitch_q  <= '0;
      level_q   <= 1'b1;
      edge_q    <= 1'b0;
      state_q   <= IDLE;
      cnt_q     <= '0;
      for (int i = 0; i < DEPTH; i++) hist_q[i] <= '0;
      sum_q     <= '0;
      fill_q    <= '0;
      raw_q     <= '0;
      avg_q     <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      glitch_q  <= glitch_d;
      level_q   <= level_d;
      edge_q    <= edge_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hist_q    <= hist_d;
      sum_q     <= sum_d;
      fill_q    <= fill_d;
      raw_q     <= raw_d;
      avg_q     <= avg_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.sensor_level = level_q;
  assign bus.edge_pulse   = edge_q;
  assign bus.period_raw   = raw_q;
  assign bus.period_avg   = avg_q;
  assign bus.period_valid = valid_q;
  assign bus.timeout      = timeout_q;

endmodule

// File: tb/tb_sensor_period_meter.sv
// tb_sensor_period_meter
//   Directed bench for sensor_period_meter with GLITCH_CYC=4, SYNC_STAGES=2,
//   TIMEOUT=1000, AVG_LOG2=3. Marks are driven so that consecutive falls are an
//   exact number of cycles apart; a negedge monitor counts edge pulses,
//   strobes and timeout rises.
module tb_sensor_period_meter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sensor_period_meter_if #(.CNT_W(32)) bus ();

  sensor_period_meter #(
    .SYNC_STAGES(2),
    .GLITCH_CYC (4),
    .CNT_W      (32),
    .TIMEOUT    (1000),
    .AVG_LOG2   (3)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  int cyc = 0;
  int ep_cnt = 0, ep_cyc = 0;
  int strobe_cnt = 0;
  int to_rise = 0, to_cyc = 0;
  logic to_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.edge_pulse) begin
      ep_cnt = ep_cnt + 1;
      ep_cyc = cyc;
    end
    if (bus.period_valid) strobe_cnt = strobe_cnt + 1;
    if (bus.timeout && !to_prev) begin
      to_rise = to_rise + 1;
      to_cyc  = cyc;
    end
    to_prev = bus.timeout;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Falls are exactly 'gap' cycles apart: 12 cycles are spent after each fall.
  task automatic mark(input int gap);
    repeat (gap - 12) @(negedge clk);
    bus.sensor_in = 1'b0;
    repeat (8) @(negedge clk);
    bus.sensor_in = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_level"},   bus.sensor_level, 1);
    check_eq({tag, "_edge"},    bus.edge_pulse,   0);
    check_eq({tag, "_raw"},     bus.period_raw,   0);
    check_eq({tag, "_avg"},     bus.period_avg,   0);
    check_eq({tag, "_valid"},   bus.period_valid, 0);
    check_eq({tag, "_timeout"}, bus.timeout,      0);
  endtask

  int base, s, e, r, fc;
  int exp_avg [8] = '{112, 125, 137, 150, 162, 175, 187, 200};

  initial begin
    bus.sensor_in = 1'b1;
    bus.enable    = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("rst");
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // 1: glitch rejection, then one accepted mark with fixed latency
    base = ep_cnt;
    bus.sensor_in = 1'b0;
    repeat (3) @(negedge clk);
    bus.sensor_in = 1'b1;
    repeat (15) @(negedge clk);
    check_eq("t1_short_no_pulse", ep_cnt, base);
    check_eq("t1_short_level", bus.sensor_level, 1);
    bus.sensor_in = 1'b0;
    fc = cyc;
    repeat (6) @(negedge clk);
    bus.sensor_in = 1'b1;
    repeat (15) @(negedge clk);
    check_eq("t1_one_pulse", ep_cnt, base + 1);
    check_eq("t1_latency", ep_cyc - fc, 6);
    check_eq("t1_raw_untouched", bus.period_raw, 0);

    // 2: nine marks at 100 cycles
    bus.enable = 1'b1;
    repeat (2) @(negedge clk);
    s = strobe_cnt;
    for (int i = 1; i <= 9; i++) begin
      mark(100);
      if (i == 1) check_eq("t2_ref_raw", bus.period_raw, 0);
      if (i == 2) check_eq("t2_raw2", bus.period_raw, 100);
      if (i == 8) begin
        check_eq("t2_no_strobe8", strobe_cnt, s);
        check_eq("t2_avg_held0", bus.period_avg, 0);
      end
      if (i == 9) begin
        check_eq("t2_strobe9", strobe_cnt, s + 1);
        check_eq("t2_avg9", bus.period_avg, 100);
        check_eq("t2_raw9", bus.period_raw, 100);
      end
    end

    // 3: period steps 100 -> 200
    s = strobe_cnt;
    for (int i = 0; i < 8; i++) begin
      mark(200);
      check_eq($sformatf("t3_avg%0d", i), bus.period_avg, exp_avg[i]);
      check_eq($sformatf("t3_strobe%0d", i), strobe_cnt, s + i + 1);
    end
    check_eq("t3_raw", bus.period_raw, 200);

    // 4: loss of marks
    s = strobe_cnt;
    r = to_rise;
    repeat (1000) @(negedge clk);
    check_eq("t4_timeout_set", bus.timeout, 1);
    check_eq("t4_timeout_rises", to_rise, r + 1);
    check_eq("t4_timeout_delay", to_cyc - (ep_cyc + 1), 1000);
    check_eq("t4_raw_held", bus.period_raw, 200);
    check_eq("t4_avg_held", bus.period_avg, 200);
    mark(100);
    check_eq("t4_timeout_clear", bus.timeout, 0);
    check_eq("t4_no_strobe_ref", strobe_cnt, s);
    check_eq("t4_no_period_ref", bus.period_raw, 200);
    for (int i = 1; i <= 8; i++) begin
      mark(100);
      if (i == 7) check_eq("t4_no_strobe7", strobe_cnt, s);
      if (i == 8) begin
        check_eq("t4_strobe8", strobe_cnt, s + 1);
        check_eq("t4_avg8", bus.period_avg, 100);
      end
    end

    // 5: mark coincides with cnt==TIMEOUT
    s = strobe_cnt;
    r = to_rise;
    mark(1000);
    check_eq("t5_raw", bus.period_raw, 1000);
    check_eq("t5_timeout", bus.timeout, 0);
    check_eq("t5_no_timeout_rise", to_rise, r);
    check_eq("t5_strobe", strobe_cnt, s + 1);
    check_eq("t5_avg", bus.period_avg, 212);

    // 5b: enable low mid-run
    bus.enable = 1'b0;
    s = strobe_cnt;
    e = ep_cnt;
    for (int i = 0; i < 3; i++) mark(100);
    check_eq("t5_dis_no_strobe", strobe_cnt, s);
    check_eq("t5_dis_edges", ep_cnt, e + 3);
    check_eq("t5_dis_raw_held", bus.period_raw, 1000);
    check_eq("t5_dis_avg_held", bus.period_avg, 212);
    repeat (1100) @(negedge clk);
    check_eq("t5_dis_timeout", bus.timeout, 0);
    bus.enable = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      mark(100);
      if (i == 8) check_eq("t5_en_no_strobe8", strobe_cnt, s);
      if (i == 9) begin
        check_eq("t5_en_strobe9", strobe_cnt, s + 1);
        check_eq("t5_en_avg", bus.period_avg, 100);
        check_eq("t5_en_raw", bus.period_raw, 100);
      end
    end

    // 6: asynchronous reset while the sensor is low mid-period
    repeat (50) @(negedge clk);
    bus.sensor_in = 1'b0;
    repeat (8) @(negedge clk);
    check_eq("t6_level_low", bus.sensor_level, 0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_values("t6_async");
    @(negedge clk);
    bus.sensor_in = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    s = strobe_cnt;
    for (int i = 1; i <= 9; i++) begin
      mark(100);
      if (i == 8) check_eq("t6_no_strobe8", strobe_cnt, s);
      if (i == 9) begin
        check_eq("t6_strobe9", strobe_cnt, s + 1);
        check_eq("t6_avg", bus.period_avg, 100);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/sensor_period_meter.md
Name: sensor_period_meter

Overview:
- Upstream conditioning and measurement stage for the print-mark sensor that drives the motor/anilox step core.
- Synchronizes and deglitches the raw active-low mark sensor, then measures the clk-cycle period between consecutive marks.
- Keeps an 8-sample moving average and flags loss of marks (soft-stop timeout).
- The core consumes period_avg/period_valid to scale its step rate and uses timeout as its soft-stop request.

Parameters:
SYNC_STAGES, 2, synchronizer flops on sensor_in (>=2)
GLITCH_CYC, 16, consecutive stable cycles required before the filtered level changes (>=1)
CNT_W, 32, period counter and output width
TIMEOUT, 500000, cycle count without a mark that raises timeout (< 2^CNT_W)
AVG_LOG2, 3, log2 of averaging depth (3 means 8 samples)

Ports:
clk  in  1  system clock, all logic on posedge
rst_n  in  1  asynchronous active-low reset
sensor_in  in  1  raw mark sensor, asynchronous, mark = falling edge
enable  in  1  measurement enable; 0 clears measurement state synchronously
sensor_level  out  1  deglitched sensor level
edge_pulse  out  1  one-cycle pulse on each accepted mark (filtered falling edge)
period_raw  out  CNT_W  last measured period in clk cycles
period_avg  out  CNT_W  moving average, sum >> AVG_LOG2
period_valid  out  1  one-cycle strobe when period_raw/period_avg update with a full history
timeout  out  1  level, marks lost

Behaviour:
- Reset (rst_n=0, async): synchronizer flops = 1, sensor_level=1, edge_pulse=0, period_raw=0, period_avg=0, period_valid=0, timeout=0, history/sum/fill=0, state IDLE.
- Sync: SYNC_STAGES flops. Deglitch: stable counter runs while the synced value differs from sensor_level and clears whenever they match. When it reaches GLITCH_CYC, sensor_level takes the synced value and the counter clears.
- Mark detection: edge_pulse=1 in the cycle sensor_level goes 1->0. Total latency from the sensor_in fall to edge_pulse = SYNC_STAGES+GLITCH_CYC cycles (+/-1 for async sampling).
- Period counter cnt (CNT_W): cleared to 1 in the cycle after each mark, incremented every cycle otherwise, saturates at TIMEOUT. The period is the cycle distance between consecutive edge_pulse assertions.
- States:
  - IDLE: no reference mark. A mark moves to ARMED. The counter is held at 0.
  - ARMED/RUN: on a mark, period_raw <= cnt. The sample is shifted into the history, sum <= sum + new - oldest, and fill increments and saturates at 2^AVG_LOG2.
- Output update latency: period_raw, period_avg and period_valid update 1 cycle after edge_pulse.
  - period_valid pulses only when fill (after the update) equals 2^AVG_LOG2. The first 7 measured periods give no strobe.
  - period_avg holds its value between strobes.
- Sum width: CNT_W+AVG_LOG2 with no overflow. period_avg = sum[CNT_W+AVG_LOG2-1:AVG_LOG2], truncating.
- Timeout: in ARMED, when cnt reaches TIMEOUT with no mark that cycle:
  - timeout <= 1, state returns to IDLE, history, sum and fill cleared;
  - period_raw and period_avg hold their last values.
  - timeout stays high until the next mark. That mark clears timeout, enters ARMED, and produces no period.
- Simultaneous mark and cnt==TIMEOUT: the mark wins, period = TIMEOUT is accepted as valid, and no timeout is raised.
- enable=0: state IDLE, cnt/history/fill/timeout cleared, period_valid=0, edge_pulse still reported. Outputs period_raw/period_avg hold. Re-enabling needs a fresh reference mark.
- Rising sensor edges only affect sensor_level. A rst_n assertion mid-period discards all history immediately.

Test Plan:
(Bench params: GLITCH_CYC=4, SYNC_STAGES=2, TIMEOUT=1000, AVG_LOG2=3.)
1. sensor_in low for 3 cycles, then high -> no edge_pulse and sensor_level stays 1. Low for 6 cycles -> exactly one edge_pulse about 6 cycles after the fall.
2. Marks every 100 cycles, 9 marks -> period_raw=100 from the 2nd mark on. No period_valid for marks 2-8. Mark 9 gives a period_valid strobe with period_avg=100.
3. Steady at 100, then the period changes to 200 -> successive period_avg = 112,125,137,150,162,175,187,200 (truncated), one strobe per mark.
4. Armed, then no mark for 1000 cycles -> timeout=1 exactly TIMEOUT cycles after the last mark update. The next mark clears timeout with no strobe. Strobes resume after 8 further periods.
5. Mark arriving exactly when cnt==1000 -> period_valid path taken, period_raw=1000, timeout stays 0. Also deassert enable mid-run -> no strobes, and resuming needs 9 marks.
6. rst_n pulsed low mid-period, asynchronously between clk edges -> all outputs immediately at their reset values. After release, first valid strobe on the 9th mark.
